// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
// Imported by the arbiter top and its result FIFO.
package wb_port_arbiter_pkg;

  localparam int DW_DEF         = 32;
  localparam int AW_DEF         = 5;
  localparam int DEPTH_DEF      = 2;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  // Arbiter state is not stored; it is recomputed every cycle from occupancy and starvation.
  function automatic logic [1:0] arb_state(input logic q_empty, input logic starved);
    if (q_empty)      return ST_EMPTY;
    else if (starved) return ST_FORCE;
    else              return ST_PEND;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding long-latency {rn, data} results awaiting a free write slot.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = AW_DEF + DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // NOTE: storage carries no reset; occupancy and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and queued long-latency results,
// forcing a pipeline stall when a queued result has waited STARVE_MAX cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wreg,
  input  logic [AW-1:0]              pipe_rn,
  input  logic [DW-1:0]              pipe_wdi,
  input  logic                       lu_valid,
  input  logic [AW-1:0]              lu_rn,
  input  logic [DW-1:0]              lu_data,
  output logic                       lu_ready,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_wn,
  output logic [DW-1:0]              rf_d,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  logic [SW-1:0]    r_starve_cnt;
  logic [CW-1:0]    w_count;
  logic [AW+DW-1:0] w_head;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_grant_pipe;
  logic [1:0]       w_state;

  wb_result_fifo #(.W(AW+DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({lu_rn, lu_data}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // A full FIFO refuses input even when the head drains in the same cycle.
  assign lu_ready = !rst && !w_full;
  assign w_push   = lu_valid && lu_ready;
  assign q_count  = w_count;
  assign w_state  = arb_state(w_count == '0, r_starve_cnt == SW'(STARVE_MAX));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant_pipe = 1'b0;
    w_pop        = 1'b0;
    stall        = 1'b0;
    if (!rst) begin
      case (w_state)
        ST_EMPTY: w_grant_pipe = pipe_wreg;
        ST_PEND: begin
          if (pipe_wreg) w_grant_pipe = 1'b1;
          else           w_pop        = 1'b1;
        end
        ST_FORCE: begin
          stall = 1'b1;
          w_pop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A grant to register 0 still uses the slot (and dequeues) but never writes.
  always_comb begin
    rf_wn = w_pop ? w_head[AW+DW-1:DW] : pipe_rn;
    rf_d  = w_pop ? w_head[DW-1:0]     : pipe_wdi;
    rf_we = (w_grant_pipe || w_pop) && (rf_wn != AW'(REG_ZERO));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_count == '0 || w_pop) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter: one record per cycle, expectations queued on drive
// and compared mid-cycle, plus a hand-written starvation sequence.
module tb_wb_port_arbiter;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  prn;
    logic [31:0] pwdi;
    logic        lv;
    logic [4:0]  lrn;
    logic [31:0] ldat;
    logic        e_we;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    logic        e_stall;
    logic        e_rdy;
    logic [1:0]  e_qc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wreg = 1'b0;
  logic [4:0]  pipe_rn = '0;
  logic [31:0] pipe_wdi = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rn = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        stall;
  logic [1:0]  q_count;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_wreg(pipe_wreg), .pipe_rn(pipe_rn), .pipe_wdi(pipe_wdi),
    .lu_valid(lu_valid), .lu_rn(lu_rn), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .stall(stall), .q_count(q_count)
  );

  function automatic vec_t mk(input logic r, input logic pw, input logic [4:0] prn,
                              input logic [31:0] pwdi, input logic lv, input logic [4:0] lrn,
                              input logic [31:0] ldat, input logic we, input logic [4:0] wn,
                              input logic [31:0] d, input logic st, input logic rdy,
                              input logic [1:0] qc);
    vec_t v;
    v.rst = r; v.pw = pw; v.prn = prn; v.pwdi = pwdi;
    v.lv = lv; v.lrn = lrn; v.ldat = ldat;
    v.e_we = we; v.e_wn = wn; v.e_d = d; v.e_stall = st; v.e_rdy = rdy; v.e_qc = qc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pipe_wreg = v.pw; pipe_rn = v.prn; pipe_wdi = v.pwdi;
    lu_valid = v.lv; lu_rn = v.lrn; lu_data = v.ldat;
  endtask

  task automatic compare(input vec_t e, input int idx);
    n_vec++;
    check("rf_we",    idx, 32'(rf_we),    32'(e.e_we));
    check("stall",    idx, 32'(stall),    32'(e.e_stall));
    check("lu_ready", idx, 32'(lu_ready), 32'(e.e_rdy));
    check("q_count",  idx, 32'(q_count),  32'(e.e_qc));
    if (e.e_we) begin
      check("rf_wn", idx, 32'(rf_wn), 32'(e.e_wn));
      check("rf_d",  idx, rf_d, e.e_d);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk); #1;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    compare(e, idx);
  endtask

  initial begin
    //            rst pw prn  pwdi          lv lrn   ldat          we wn    d             st rdy qc
    vecs.push_back(mk(1, 1, 5'd5, 32'h5555, 1, 5'd3, 32'h3333,    0, 5'd0, 32'h0,     0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 5'd5, 32'h5555, 1, 5'd3, 32'h3333,    0, 5'd0, 32'h0,     0, 0, 2'd0));
    vecs.push_back(mk(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,       1, 5'd5, 32'h1234,  0, 1, 2'd0));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    1, 5'd7, 32'hAAAA,    0, 5'd0, 32'h0,     0, 1, 2'd0));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       1, 5'd7, 32'hAAAA,  0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       0, 5'd0, 32'h0,     0, 1, 2'd0));
    // one queued entry loses four slots to the pipe, then forces a stall
    vecs.push_back(mk(0, 1, 5'd1, 32'h11,   1, 5'd9, 32'h99,      1, 5'd1, 32'h11,    0, 1, 2'd0));
    vecs.push_back(mk(0, 1, 5'd2, 32'h22,   0, 5'd0, 32'h0,       1, 5'd2, 32'h22,    0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd3, 32'h33,   0, 5'd0, 32'h0,       1, 5'd3, 32'h33,    0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd4, 32'h44,   0, 5'd0, 32'h0,       1, 5'd4, 32'h44,    0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd5, 32'h55,   0, 5'd0, 32'h0,       1, 5'd5, 32'h55,    0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd6, 32'h66,   0, 5'd0, 32'h0,       1, 5'd9, 32'h99,    1, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd6, 32'h66,   0, 5'd0, 32'h0,       1, 5'd6, 32'h66,    0, 1, 2'd0));
    // fill to full, third result held until the cycle after a dequeue
    vecs.push_back(mk(0, 1, 5'd10, 32'hA0,  1, 5'd11, 32'hB1,     1, 5'd10, 32'hA0,   0, 1, 2'd0));
    vecs.push_back(mk(0, 1, 5'd10, 32'hA0,  1, 5'd12, 32'hB2,     1, 5'd10, 32'hA0,   0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 5'd10, 32'hA0,  1, 5'd13, 32'hB3,     1, 5'd10, 32'hA0,   0, 0, 2'd2));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    1, 5'd13, 32'hB3,     1, 5'd11, 32'hB1,   0, 0, 2'd2));
    vecs.push_back(mk(0, 1, 5'd10, 32'hA0,  1, 5'd13, 32'hB3,     1, 5'd10, 32'hA0,   0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       1, 5'd12, 32'hB2,   0, 0, 2'd2));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       1, 5'd13, 32'hB3,   0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       0, 5'd0, 32'h0,     0, 1, 2'd0));
    // queued write to register 0 drains without a write enable
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    1, 5'd0, 32'hCC,      0, 5'd0, 32'h0,     0, 1, 2'd0));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       0, 5'd0, 32'h0,     0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       0, 5'd0, 32'h0,     0, 1, 2'd0));
    // reset with an entry queued: outputs gated, no enqueue, queue cleared
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    1, 5'd4, 32'h44,      0, 5'd0, 32'h0,     0, 1, 2'd0));
    vecs.push_back(mk(1, 1, 5'd8, 32'h88,   1, 5'd6, 32'h66,      0, 5'd0, 32'h0,     0, 0, 2'd1));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,       0, 5'd0, 32'h0,     0, 1, 2'd0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: enqueue, then keep the pipe busy and measure how long the head waits.
    begin
      int   lost;
      logic seen;
      lost = 0;
      seen = 1'b0;
      @(posedge clk); #1;
      drive(mk(0, 0, 5'd0, 32'h0, 1, 5'd14, 32'hE0E0, 0, 5'd0, 32'h0, 0, 1, 2'd0));
      @(negedge clk);
      n_vec++;
      check("hs_enq_qcount", 100, 32'(q_count), 32'd0);
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk); #1;
        drive(mk(0, 1, 5'd15, 32'hF0F0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0));
        @(negedge clk);
        n_vec++;
        if (stall) begin
          seen = 1'b1;
          check("hs_force_wn", 101 + c, 32'(rf_wn), 32'd14);
          check("hs_force_d",  101 + c, rf_d, 32'hE0E0);
          check("hs_force_we", 101 + c, 32'(rf_we), 32'd1);
        end else begin
          lost++;
          check("hs_pipe_wn", 101 + c, 32'(rf_wn), 32'd15);
          check("hs_pipe_we", 101 + c, 32'(rf_we), 32'd1);
        end
      end
      n_vec++;
      check("hs_stall_seen", 120, 32'(seen), 32'd1);
      check("hs_lost_slots", 120, 32'(lost), 32'd4);
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      check("hs_post_stall", 121, 32'(stall), 32'd0);
      check("hs_post_wn",    121, 32'(rf_wn), 32'd15);
      check("hs_post_qc",    121, 32'(q_count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
